// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode/funct constants, ALU op and FSM state enums, instruction decode
package alu_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SLT,
        OP_SLTU,
        OP_SLL,
        OP_SRL,
        OP_ILLEGAL
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    // ADDI is reported as OP_ADD; the datapath substitutes the immediate for rs2.
    function automatic alu_op_t decode(input logic [31:0] instr);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = instr[6:0];
        f3  = instr[14:12];
        f7  = instr[31:25];
        decode = OP_ILLEGAL;
        if (opc == OPC_ITYPE && f3 == F3_ADD_SUB) begin
            decode = OP_ADD;
        end else if (opc == OPC_RTYPE) begin
            case ({f7, f3})
                {F7_BASE,   F3_ADD_SUB}: decode = OP_ADD;
                {F7_ALT,    F3_ADD_SUB}: decode = OP_SUB;
                {F7_MULDIV, F3_ADD_SUB}: decode = OP_MUL;
                {F7_BASE,   F3_AND}:     decode = OP_AND;
                {F7_BASE,   F3_OR}:      decode = OP_OR;
                {F7_BASE,   F3_XOR}:     decode = OP_XOR;
                {F7_BASE,   F3_SLT}:     decode = OP_SLT;
                {F7_BASE,   F3_SLTU}:    decode = OP_SLTU;
                {F7_BASE,   F3_SLL}:     decode = OP_SLL;
                {F7_BASE,   F3_SRL}:     decode = OP_SRL;
                default:                 decode = OP_ILLEGAL;
            endcase
        end
    endfunction

endpackage

// File: rtl/alu_issue_sequencer_if.sv
// rtl/alu_issue_sequencer_if.sv - instruction push and writeback signal bundle
interface alu_issue_sequencer_if #(
    parameter int DATA_W = 5
) ();
    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              illegal;

    modport master (
        output instr_valid, instr,
        input  instr_ready, wb_valid, wb_rd, wb_data, illegal
    );

    modport slave (
        input  instr_valid, instr,
        output instr_ready, wb_valid, wb_rd, wb_data, illegal
    );
endinterface

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous count-based FIFO buffering instruction words
module instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array: written on accepted push, never reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - (AW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/alu_issue_sequencer.sv
// rtl/alu_issue_sequencer.sv - in-order decode/execute/writeback sequencer with register file
module alu_issue_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_issue_sequencer_if.slave bus,
    output logic                 busy,
    output logic [15:0]          retired,
    input  logic [4:0]           dbg_addr,
    output logic [DATA_W-1:0]    dbg_data
);
    localparam int CW = $clog2(DATA_W);

    state_t            state_q;
    state_t            state_d;
    logic [31:0]       fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [31:0]       ir_q;
    alu_op_t           op_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] acc_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] res_q;
    logic [4:0]        wb_rd_q;
    logic [DATA_W-1:0] regs [32];
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mul_sum;
    logic              is_itype;

    assign pop             = (state_q == S_IDLE) && !fifo_empty;
    assign bus.instr_ready = !fifo_full;
    assign bus.wb_data     = res_q;
    assign bus.wb_rd       = wb_rd_q;
    assign dbg_data        = regs[dbg_addr];
    assign is_itype        = (ir_q[6:0] == OPC_ITYPE);

    instr_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.instr_valid),
        .din   (bus.instr),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state output pulses; MUL stays in EXEC until its counter reaches 0.
    always_comb begin
        state_d      = state_q;
        bus.wb_valid = 1'b0;
        bus.illegal  = 1'b0;
        busy         = (state_q != S_IDLE) || !fifo_empty;
        case (state_q)
            S_IDLE:   if (!fifo_empty) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   if (op_q != OP_MUL || cnt_q == '0) state_d = S_WB;
            S_WB: begin
                state_d      = S_IDLE;
                bus.wb_valid = (op_q != OP_ILLEGAL);
                bus.illegal  = (op_q == OP_ILLEGAL);
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Single-cycle ALU result and one shift-add step of the multiplier.
    always_comb begin
        alu_res = '0;
        mul_sum = acc_q + (b_q[0] ? a_q : '0);
        case (op_q)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
            OP_SLL:  alu_res = a_q << b_q;
            OP_SRL:  alu_res = a_q >> b_q;
            default: alu_res = '0;
        endcase
    end

    // Datapath: fetch from FIFO, latch operands, iterate MUL, commit result and register write.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q    <= '0;
            op_q    <= OP_ILLEGAL;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            wb_rd_q <= '0;
            retired <= '0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (pop) begin
                ir_q <= fifo_dout;
            end
            case (state_q)
                S_DECODE: begin
                    op_q  <= decode(ir_q);
                    rd_q  <= ir_q[11:7];
                    a_q   <= regs[ir_q[19:15]];
                    b_q   <= is_itype ? DATA_W'($signed(ir_q[31:20])) : regs[ir_q[24:20]];
                    acc_q <= '0;
                    cnt_q <= CW'(DATA_W - 1);
                end
                S_EXEC: begin
                    if (op_q == OP_MUL) begin
                        // Multiplicand shifts left, multiplier shifts right, one bit per cycle.
                        acc_q <= mul_sum;
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == '0) begin
                            res_q   <= mul_sum;
                            wb_rd_q <= rd_q;
                        end
                    end else if (op_q != OP_ILLEGAL) begin
                        res_q   <= alu_res;
                        wb_rd_q <= rd_q;
                    end
                end
                S_WB: begin
                    retired <= retired + 16'd1;
                    if (op_q != OP_ILLEGAL && rd_q != 5'd0) begin
                        regs[rd_q] <= res_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb/tb_alu_issue_sequencer.sv - directed and random checks against a behavioural instruction model
module tb_alu_issue_sequencer;
    localparam int DATA_W = 5;
    localparam int DEPTH  = 4;
    localparam int MASK   = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              busy;
    logic [15:0]       retired;
    logic [4:0]        dbg_addr = '0;
    logic [DATA_W-1:0] dbg_data;

    alu_issue_sequencer_if #(.DATA_W(DATA_W)) bif ();

    alu_issue_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif),
        .busy     (busy),
        .retired  (retired),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit legal;
        int rd;
        int data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   m_reg [32];
    int   m_retired = 0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_wb_cyc = 0;
    int   last_push_cyc = 0;
    bit   mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= (1 << (DATA_W - 1))) ? v - (1 << DATA_W) : v;
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input int imm, input int rs1, input int rd);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    // Architectural effect of one instruction, applied in program order.
    task automatic model_accept(input logic [31:0] w);
        int a, b, r, rd, imm;
        bit legal;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25]; rd = int'(w[11:7]);
        a = m_reg[w[19:15]]; b = m_reg[w[24:20]];
        legal = 1; r = 0;
        if (opc == 7'h13 && f3 == 3'd0) begin
            imm = $signed(w[31:20]);
            r = a + imm;
        end else if (opc == 7'h33 && f7 == 7'h00) begin
            case (f3)
                3'd0: r = a + b;
                3'd1: r = (b >= DATA_W) ? 0 : (a << b);
                3'd2: r = (to_signed(a) < to_signed(b)) ? 1 : 0;
                3'd3: r = (a < b) ? 1 : 0;
                3'd4: r = a ^ b;
                3'd5: r = (b >= DATA_W) ? 0 : (a >> b);
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
            r = a - b;
        end else if (opc == 7'h33 && f7 == 7'h01 && f3 == 3'd0) begin
            r = a * b;
        end else begin
            legal = 0;
        end
        r = r & MASK;
        if (legal && rd != 0) m_reg[rd] = r;
        m_retired++;
        exp_q.push_back('{legal, rd, r});
    endtask

    // Holds instr_valid until the word is taken; starts and ends on a falling edge.
    task automatic push(input logic [31:0] w, output int stalls);
        stalls = 0;
        bif.instr = w;
        bif.instr_valid = 1'b1;
        forever begin
            if (bif.instr_ready) begin
                @(posedge clk);
                model_accept(w);
                @(negedge clk);
                last_push_cyc = cyc;
                break;
            end
            stalls++;
            if (stalls > 100) begin
                check("push_timeout", 32'(stalls), 32'd0);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        check("idle_timeout", {31'd0, busy}, 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("retired", {16'd0, retired}, 32'(m_retired & 16'hffff));
    endtask

    task automatic run(input logic [31:0] w);
        int s;
        push(w, s);
        bif.instr_valid = 1'b0;
        wait_idle();
    endtask

    task automatic sweep(input string tag);
        for (int r = 0; r < 32; r++) begin
            dbg_addr = 5'(r);
            #1;
            check($sformatf("%s_x%0d", tag, r), 32'(dbg_data), 32'(m_reg[r]));
        end
    endtask

    task automatic dbg_check(input string tag, input int r, input int exp);
        dbg_addr = 5'(r);
        #1;
        check(tag, 32'(dbg_data), 32'(exp));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [9:0] pairs [10] = '{{7'h00, 3'd0}, {7'h20, 3'd0}, {7'h01, 3'd0}, {7'h00, 3'd7},
                                   {7'h00, 3'd6}, {7'h00, 3'd4}, {7'h00, 3'd2}, {7'h00, 3'd3},
                                   {7'h00, 3'd1}, {7'h00, 3'd5}};
        int k, rd, rs1, rs2;
        logic [2:0] f3;
        k = $urandom_range(0, 12);
        rd = $urandom_range(0, 7); rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7);
        f3 = 3'($urandom_range(1, 7));
        if (k < 10) return rtype(pairs[k][9:3], rs2, rs1, pairs[k][2:0], rd);
        if (k < 12) return itype($urandom_range(0, 4095), rs1, rd);
        case ($urandom_range(0, 3))
            0: return 32'h0000_0073;
            1: return rtype(7'h20, rs2, rs1, f3, rd);
            2: return rtype(7'h01, rs2, rs1, f3, rd);
            default: return {12'(rs2), 5'(rs1), f3, 5'(rd), 7'b0010011};
        endcase
    endfunction

    // Writeback monitor: every pulse must match the oldest outstanding model result.
    always @(negedge clk) begin
        if (mon_en && !rst && (bif.wb_valid || bif.illegal)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, bif.wb_valid, bif.illegal}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_valid", {31'd0, bif.wb_valid}, {31'd0, mon_e.legal});
                check("illegal", {31'd0, bif.illegal}, {31'd0, !mon_e.legal});
                if (mon_e.legal) begin
                    check("wb_rd", {27'd0, bif.wb_rd}, 32'(mon_e.rd));
                    check("wb_data", 32'(bif.wb_data), 32'(mon_e.data));
                end
            end
            last_wb_cyc = cyc;
        end
    end

    initial begin
        int s;
        int first_stall;
        int r0;
        logic [31:0] burst [6];

        bif.instr_valid = 1'b0;
        bif.instr = '0;
        foreach (m_reg[i]) m_reg[i] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, bif.instr_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_retired", {16'd0, retired}, 32'd0);
        check("rst_pulses", {30'd0, bif.wb_valid, bif.illegal}, 32'd0);
        check("rst_wb_rd", {27'd0, bif.wb_rd}, 32'd0);
        check("rst_wb_data", 32'(bif.wb_data), 32'd0);
        sweep("rst");
        mon_en = 1;

        // ADD / SUB with non-MUL latency and held outputs
        run(itype(2, 0, 2));
        run(itype(4, 0, 4));
        run(rtype(7'h00, 4, 2, 3'd0, 1));
        check("lat_add", 32'(last_wb_cyc - last_push_cyc), 32'd3);
        dbg_check("t1_add", 1, 6);
        check("wb_data_held", 32'(bif.wb_data), 32'd6);
        run(rtype(7'h20, 4, 2, 3'd0, 1));
        dbg_check("t1_sub", 1, 30);

        // MUL latency, AND, OR
        run(rtype(7'h01, 4, 2, 3'd0, 3));
        check("lat_mul", 32'(last_wb_cyc - last_push_cyc), 32'(2 + DATA_W));
        dbg_check("t2_mul", 3, 8);
        run(rtype(7'h00, 4, 2, 3'd7, 5));
        dbg_check("t2_and", 5, 0);
        run(itype(6, 0, 6));
        run(rtype(7'h00, 6, 2, 3'd6, 7));
        dbg_check("t2_or", 7, 6);

        // Compares and shifts, including shift amount >= DATA_W
        run(itype(-5, 0, 27));
        run(itype(3, 0, 3));
        run(rtype(7'h00, 3, 27, 3'd2, 8));
        run(rtype(7'h00, 3, 27, 3'd3, 9));
        run(itype(1, 0, 1));
        run(rtype(7'h00, 1, 3, 3'd5, 10));
        run(rtype(7'h00, 1, 3, 3'd1, 11));
        run(itype(7, 0, 12));
        run(rtype(7'h00, 12, 3, 3'd1, 13));
        dbg_check("t3_slt", 8, 1);
        dbg_check("t3_sltu", 9, 0);
        dbg_check("t3_srl", 10, 1);
        dbg_check("t3_sll", 11, 6);
        dbg_check("t3_sll7", 13, 0);
        sweep("t3");

        // Back-to-back burst: the sequencer takes the first word, so DEPTH more fill the FIFO
        burst = '{itype(9, 0, 14), itype(3, 0, 15), rtype(7'h00, 15, 14, 3'd0, 16),
                  rtype(7'h20, 14, 15, 3'd0, 17), rtype(7'h01, 15, 14, 3'd0, 18),
                  rtype(7'h00, 18, 16, 3'd4, 19)};
        r0 = int'(retired);
        first_stall = -1;
        for (int i = 0; i < 6; i++) begin
            push(burst[i], s);
            if (s > 0 && first_stall < 0) first_stall = i;
        end
        bif.instr_valid = 1'b0;
        check("t4_first_stall", 32'(first_stall), 32'(DEPTH + 1));
        wait_idle();
        check("t4_retired6", {16'd0, retired}, 32'((r0 + 6) & 16'hffff));
        sweep("t4");

        // Illegal words and writes to x0
        run(32'h0000_0073);
        run(rtype(7'h20, 2, 1, 3'd7, 5));
        sweep("t5_illegal");
        run(itype(5, 0, 0));
        dbg_check("t5_x0", 0, 0);

        // Random program with random gaps
        for (int n = 0; n < 60; n++) begin
            push(rand_instr(), s);
            if ($urandom_range(0, 3) == 0) begin
                bif.instr_valid = 1'b0;
                repeat ($urandom_range(1, 6)) @(negedge clk);
            end
        end
        bif.instr_valid = 1'b0;
        wait_idle();
        sweep("rand");

        // Reset in the middle of a MUL
        push(rtype(7'h01, 4, 2, 3'd0, 3), s);
        bif.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        foreach (m_reg[i]) m_reg[i] = 0;
        m_retired = 0;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_retired", {16'd0, retired}, 32'd0);
        check("t6_ready", {31'd0, bif.instr_ready}, 32'd1);
        check("t6_pulses", {30'd0, bif.wb_valid, bif.illegal}, 32'd0);
        check("t6_wb_data", 32'(bif.wb_data), 32'd0);
        sweep("t6");
        repeat (12) @(negedge clk);
        check("t6_still_idle", {31'd0, busy}, 32'd0);
        check("t6_retired_after", {16'd0, retired}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
